mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port RAM between the pipeline MEM stage (port 0) and the
//   loader/dump engine (port 1). Port 0 has fixed priority. A port that is
//   granted with its lock input high becomes the burst owner and keeps the RAM
//   for up to MAX_BURST consecutive grants. After that it must re-arbitrate for
//   one cycle. Grants are combinational. Read data is registered, so it arrives
//   one cycle after the granted read.
//
//   Optional feature: define ARB_STARVE_GUARD_EN to add a starvation guard.
//   When port 1 has been denied MAX_WAIT consecutive cycles, it is forced
//   through, even over a locked port-0 burst.
//
// Ports
//   clk, clear                      clock, async active-low reset
//   p0_req/wr/lock, p0_addr/wdata   pipeline request
//   p1_req/wr/lock, p1_addr/wdata   loader request
//   p0_gnt, p1_gnt, p0_stall        combinational grant / pipeline stall
//   rdata, p0_rvalid, p1_rvalid     registered read return
//   mem_wr, mem_rd, mem_addr,
//   mem_wdata, mem_rdata            RAM interface (mem_rdata is combinational)
module mem_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 24,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_stall,
    output logic [DATA_W-1:0] rdata,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The 4-bit counters only cover limits in the range 1..15.
    if (MAX_WAIT < 1 || MAX_WAIT > 15 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_param_check
        $error("mem_port_arbiter: MAX_WAIT and MAX_BURST must be in 1..15");
    end

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state;
    logic [3:0] burst_cnt;
    logic       force1;
    logic       keep0, keep1;
    logic       g0, g1;
    logic       gnt_locked;
    logic [3:0] cnt_next;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0] wait_cnt;

    // Counts consecutive cycles in which port 1 asks but is refused.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear)
            wait_cnt <= '0;
        else if (p1_req && !g1)
            wait_cnt <= wait_cnt + 4'd1;
        else
            wait_cnt <= '0;
    end

    assign force1 = p1_req && (wait_cnt == MAX_WAIT_C);
`else
    assign force1 = 1'b0;
`endif

    // Priority: starvation override > locked owner > fixed p0-over-p1.
    // Reset gates everything so the RAM sees no access while clear is low.
    always_comb begin
        keep0 = (state == OWN0) && p0_req && p0_lock && (burst_cnt < MAX_BURST_C);
        keep1 = (state == OWN1) && p1_req && p1_lock && (burst_cnt < MAX_BURST_C);
        g0 = 1'b0;
        g1 = 1'b0;
        if (clear) begin
            if (force1)      g1 = 1'b1;
            else if (keep0)  g0 = 1'b1;
            else if (keep1)  g1 = 1'b1;
            else if (p0_req) g0 = 1'b1;
            else if (p1_req) g1 = 1'b1;
        end
    end

    assign p0_gnt   = g0;
    assign p1_gnt   = g1;
    assign p0_stall = clear && p0_req && !g0;

    always_comb begin
        mem_wr    = (g0 && p0_wr) || (g1 && p1_wr);
        mem_rd    = (g0 && !p0_wr) || (g1 && !p1_wr);
        mem_addr  = g0 ? p0_addr  : (g1 ? p1_addr  : '0);
        mem_wdata = g0 ? p0_wdata : (g1 ? p1_wdata : '0);
    end

    // A locked grant that continues the current owner extends the burst.
    // Any other locked grant starts a new burst at 1.
    assign gnt_locked = (g0 && p0_lock) || (g1 && p1_lock);
    assign cnt_next   = ((g0 && state == OWN0) || (g1 && state == OWN1)) ?
                        burst_cnt + 4'd1 : 4'd1;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rdata     <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= g0 && !p0_wr;
            p1_rvalid <= g1 && !p1_wr;
            if (mem_rd)
                rdata <= mem_rdata;
            // A full burst drops ownership, so the next cycle re-arbitrates as IDLE.
            if (gnt_locked && cnt_next != MAX_BURST_C) begin
                state     <= g0 ? OWN0 : OWN1;
                burst_cnt <= cnt_next;
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A reference model is evaluated once per cycle.
// The model tracks the lock owner, burst length and port-1 wait time, and
// keeps its own copy of RAM. It checks the combinational grant and RAM drive
// outputs, and it queues the expected read returns. A separate monitor pops
// that queue one cycle later and compares the registered read data.
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 24;
    localparam int MW = 4;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          clear;
    logic          p0_req, p0_wr, p0_lock, p1_req, p1_wr, p1_lock;
    logic [AW-1:0] p0_addr, p1_addr, mem_addr;
    logic [DW-1:0] p0_wdata, p1_wdata, mem_wdata, mem_rdata, rdata;
    logic          p0_gnt, p1_gnt, p0_stall, p0_rvalid, p1_rvalid, mem_wr, mem_rd;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    // Model state.
    int owner = 0;   // 0 none, 1 port0, 2 port1
    int bcnt  = 0;
    int wcnt  = 0;
    int mg    = 0;   // model grant of the last evaluated cycle
    int dg    = 0;   // DUT grant observed in that cycle
    bit [DW-1:0] mram[64];

    // RAM behind the DUT. Unwritten words read as twice their address.
    bit [DW-1:0] ram[64];
    bit          ram_wr[64];

    function automatic logic [DW-1:0] init_word(input logic [5:0] a);
        return DW'(a) << 1;
    endfunction

    assign mem_rdata = ram_wr[mem_addr[5:0]] ? ram[mem_addr[5:0]] : init_word(mem_addr[5:0]);

    always @(posedge clk)
        if (mem_wr) begin
            ram[mem_addr[5:0]]    <= mem_wdata;
            ram_wr[mem_addr[5:0]] <= 1'b1;
        end

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW), .MAX_BURST(MB)) dut (
        .clk(clk), .clear(clear),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_stall(p0_stall),
        .rdata(rdata), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0;
        bcnt  = 0;
        wcnt  = 0;
    endtask

    // One arbitration cycle of the reference model, checked against the DUT.
    task automatic model_cycle();
        int            g;
        bit            force_p1;
        logic          wr, lk;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        force_p1 = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        force_p1 = p1_req && (wcnt == MW);
`endif
        if (force_p1)                                        g = 2;
        else if (owner == 1 && p0_req && p0_lock && bcnt < MB) g = 1;
        else if (owner == 2 && p1_req && p1_lock && bcnt < MB) g = 2;
        else if (p0_req)                                     g = 1;
        else if (p1_req)                                     g = 2;
        else                                                 g = 0;

        wr = (g == 1) ? p0_wr    : p1_wr;
        lk = (g == 1) ? p0_lock  : (g == 2) ? p1_lock : 1'b0;
        a  = (g == 1) ? p0_addr  : p1_addr;
        wd = (g == 1) ? p0_wdata : p1_wdata;

        dg = p0_gnt ? 1 : (p1_gnt ? 2 : 0);
        chk("p0_gnt",    p0_gnt,    g == 1);
        chk("p1_gnt",    p1_gnt,    g == 2);
        chk("p0_stall",  p0_stall,  p0_req && g != 1);
        chk("mem_wr",    mem_wr,    g != 0 && wr);
        chk("mem_rd",    mem_rd,    g != 0 && !wr);
        chk("mem_addr",  mem_addr,  (g != 0) ? a  : '0);
        chk("mem_wdata", mem_wdata, (g != 0) ? wd : '0);

        if (g != 0) begin
            if (wr) mram[a[5:0]] = wd;
            else    exp_q.push_back('{g - 1, mram[a[5:0]]});
        end

        if (g != 0 && lk) begin
            bcnt = (owner == g) ? bcnt + 1 : 1;
            if (bcnt == MB) begin owner = 0; bcnt = 0; end
            else owner = g;
        end else begin
            owner = 0;
            bcnt  = 0;
        end
        wcnt = (p1_req && g != 2) ? wcnt + 1 : 0;
        mg   = g;
    endtask

    // Inputs are set 2 units after a rising edge. They are checked at +4,
    // and the call returns 2 units after the next rising edge.
    task automatic tick();
        #2;
        model_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_wr = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_wr = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    // Read-return monitor: samples 1 unit after each rising edge.
    initial begin : monitor
        rsp_t          r;
        logic [DW-1:0] last_rd;
        last_rd = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!clear) begin
                last_rd = '0;
            end else if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("p0_rvalid", p0_rvalid, r.port == 0);
                chk("p1_rvalid", p1_rvalid, r.port == 1);
                chk("rdata",     rdata,     r.data);
                last_rd = r.data;
            end else begin
                chk("no_rvalid",  {p0_rvalid, p1_rvalid}, 2'b00);
                chk("rdata_hold", rdata, last_rd);
            end
        end
    end

    initial begin : driver
        int n_words, p1_cnt, p1_at_p0, starve_cnt;
        bit p0_pend, p0_done;
        for (int i = 0; i < 64; i++) mram[i] = init_word(6'(i));
        idle_inputs();
        clear = 1'b1;
        #1 clear = 1'b0;

        // While in reset, requests must be masked and every output must read 0.
        @(posedge clk);
        #2;
        p0_req = 1; p1_req = 1; p1_wr = 1; p0_addr = 24'h5; p1_addr = 24'h6;
        #2;
        chk("rst_p0_gnt",    p0_gnt,    0);
        chk("rst_p1_gnt",    p1_gnt,    0);
        chk("rst_p0_stall",  p0_stall,  0);
        chk("rst_mem",       {mem_wr, mem_rd}, 0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_rdata",     rdata,     0);
        chk("rst_rvalid",    {p0_rvalid, p1_rvalid}, 0);
        @(posedge clk);
        #2;
        idle_inputs();
        clear = 1'b1;
        model_reset();

        // Port 0 reads address 5 while port 1 is idle; 0xA returns a cycle later.
        p0_req = 1; p0_addr = 24'h5;
        tick();
        idle_inputs();
        tick();

        // Both ports request reads without locks, so port 0 wins.
        for (int c = 0; c < 6; c++) begin
            p0_req = 1; p0_addr = AW'($urandom_range(0, 63));
            p1_req = 1; p1_addr = AW'($urandom_range(0, 63));
            tick();
        end
        idle_inputs();
        p1_req = 1; p1_addr = 24'h2;
        tick();
        idle_inputs();
        tick();

        // Port 1 runs a 10-word locked write burst to 0x10. Port 0 arrives mid-burst.
        n_words = 0; p0_pend = 0; p0_done = 0; p1_cnt = 0; p1_at_p0 = -1;
        for (int c = 0; c < 40 && n_words < 10; c++) begin
            if (n_words == 1 && !p0_done) p0_pend = 1;
            p1_req = 1; p1_wr = 1; p1_lock = 1;
            p1_addr = AW'(32'h10 + n_words); p1_wdata = $urandom;
            p0_req = p0_pend; p0_wr = 0; p0_addr = 24'h9;
            tick();
            if (dg == 2) p1_cnt++;
            if (dg == 1 && p1_at_p0 < 0) p1_at_p0 = p1_cnt;
            if (mg == 2) n_words++;
            if (mg == 1) begin p0_pend = 0; p0_done = 1; end
        end
        chk("burst_words", n_words, 10);
        chk("burst_len_before_p0", p1_at_p0, MB);
        idle_inputs();
        tick();
        p1_req = 1; p1_addr = 24'h10;
        tick();
        p1_addr = 24'h19;
        tick();
        idle_inputs();
        tick();

        // Reset arrives during a granted port-1 read, so that read never returns.
        p1_req = 1; p1_wr = 0; p1_addr = 24'h7;
        #2;
        model_cycle();
        #2;
        clear = 1'b0;
        p0_req = 1;
        exp_q.delete();
        model_reset();
        #1;
        chk("arst_gnt",    {p0_gnt, p1_gnt}, 0);
        chk("arst_stall",  p0_stall, 0);
        chk("arst_mem",    {mem_wr, mem_rd}, 0);
        chk("arst_addr",   mem_addr, 0);
        chk("arst_wdata",  mem_wdata, 0);
        chk("arst_rdata",  rdata, 0);
        chk("arst_rvalid", {p0_rvalid, p1_rvalid}, 0);
        @(posedge clk);
        #2;
        idle_inputs();
        clear = 1'b1;
        tick();
        tick();

        // Port 0 requests for 20 cycles while port 1 keeps asking.
        starve_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            p0_req = 1; p0_wr = 1'($urandom_range(0, 1)); p0_addr = AW'($urandom_range(32, 63));
            p0_wdata = $urandom;
            p1_req = 1; p1_addr = AW'($urandom_range(0, 63));
            tick();
            if (dg == 2) starve_cnt++;
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("p1_forced_grants", starve_cnt, 20 / (MW + 1));
`else
        chk("p1_starved", starve_cnt, 0);
`endif
        idle_inputs();
        tick();

        // Port 0 writes 0x1234 to address 3; port 1 then reads it back.
        p0_req = 1; p0_wr = 1; p0_addr = 24'h3; p0_wdata = 32'h1234;
        tick();
        idle_inputs();
        p1_req = 1; p1_addr = 24'h3;
        tick();
        idle_inputs();
        tick();

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            p0_req  = ($urandom_range(0, 3) != 0);
            p0_wr   = 1'($urandom_range(0, 1));
            p0_lock = 1'($urandom_range(0, 1));
            p0_addr = AW'($urandom_range(0, 63));
            p0_wdata = $urandom;
            p1_req  = ($urandom_range(0, 3) != 0);
            p1_wr   = 1'($urandom_range(0, 1));
            p1_lock = 1'($urandom_range(0, 1));
            p1_addr = AW'($urandom_range(0, 63));
            p1_wdata = $urandom;
            tick();
        end
        idle_inputs();
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
